ring_seq_ctrl: RTL and testbench

Controller for a one-hot ring position sequencer. It feeds a downstream character coder that maps each one-hot position to a display character. The block starts, stops and paces the ring. Each position is presented to the consumer with a valid/ready handshake, and the block counts completed passes. It replaces free-running rotation on every clock edge with a scheduled, back-pressurable sequence.

---
 rtl/ring_seq_ctrl.sv | 159 +++++++++++++++
 tb/tb_ring_seq_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/ring_seq_ctrl.sv
// ring_seq_ctrl: start/stop/pacing controller for a one-hot ring position sequencer.
// Each ring position is offered to a downstream consumer with a valid/ready handshake.
// The block counts completed passes around the ring.
//
// Ports:
//   CLK        clock; all state changes happen on the rising edge
//   RST        synchronous, active-high reset
//   start      begins a sequence; only sampled in IDLE
//   stop       aborts the sequence and returns to IDLE
//   out_ready  consumer accepts the current position
//   dir        (SEQ_REVERSE_EN only) 0 = rotate toward MSB, 1 = rotate toward LSB
//   q          one-hot position; bit 0 = position 0
//   idx        binary index of the set bit of q
//   out_valid  q/idx hold a position to transfer (high in RUN)
//   busy       high while in RUN
//   done       one-cycle pulse on sequence completion
//   loop_cnt   passes completed since the last start
//
// Optional feature macro: SEQ_REVERSE_EN adds the dir input for reverse rotation.
// Pass counting uses a beat counter, so a pass is N handshakes in any direction mix.
module ring_seq_ctrl #(
    parameter int unsigned N     = 17,
    parameter int unsigned LOOPS = 1,
    parameter int unsigned CW    = 5
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          start,
    input  logic          stop,
    input  logic          out_ready,
`ifdef SEQ_REVERSE_EN
    input  logic          dir,
`endif
    output logic [N-1:0]  q,
    output logic [CW-1:0] idx,
    output logic          out_valid,
    output logic          busy,
    output logic          done,
    output logic [7:0]    loop_cnt
);

    localparam logic [N-1:0]  Q_HOME = N'(1);
    localparam logic [CW-1:0] LAST   = CW'(N - 1);
    localparam logic [7:0]    LOOPS8 = 8'(LOOPS);
    localparam bit            FINITE = (LOOPS != 0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t        state;
    state_t        state_d;
    logic [N-1:0]  q_d;
    logic [CW-1:0] idx_d;
    logic [CW-1:0] bcnt;
    logic [CW-1:0] bcnt_d;
    logic [7:0]    loop_d;

    logic rev_c;
    logic hs_c;
    logic last_beat_c;
    logic last_pass_c;

    // Direction select; forward-only when the reverse feature is not built in.
`ifdef SEQ_REVERSE_EN
    assign rev_c = dir;
`else
    assign rev_c = 1'b0;
`endif

    assign hs_c        = (state == ST_RUN) && out_ready;
    assign last_beat_c = (bcnt == LAST);
    assign last_pass_c = FINITE && ((loop_cnt + 8'd1) == LOOPS8);

    // State, position and counter registers; outputs registered from next state.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= ST_IDLE;
            q         <= Q_HOME;
            idx       <= '0;
            bcnt      <= '0;
            loop_cnt  <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_d;
            q         <= q_d;
            idx       <= idx_d;
            bcnt      <= bcnt_d;
            loop_cnt  <= loop_d;
            out_valid <= (state_d == ST_RUN);
            busy      <= (state_d == ST_RUN);
            done      <= (state_d == ST_DONE);
        end
    end

    // Next-state, rotation and pass counting.
    always_comb begin
        state_d = state;
        q_d     = q;
        idx_d   = idx;
        bcnt_d  = bcnt;
        loop_d  = loop_cnt;

        unique case (state)
            ST_IDLE: begin
                if (start && !stop) begin
                    state_d = ST_RUN;
                    q_d     = Q_HOME;
                    idx_d   = '0;
                    bcnt_d  = '0;
                    loop_d  = '0;
                end
            end

            ST_RUN: begin
                // stop wins over advancing; a coincident transfer is not counted as a pass
                if (stop) begin
                    state_d = ST_IDLE;
                    q_d     = Q_HOME;
                    idx_d   = '0;
                    bcnt_d  = '0;
                end else if (hs_c) begin
                    if (rev_c) begin
                        q_d   = {q[0], q[N-1:1]};
                        idx_d = (idx == '0) ? LAST : idx - CW'(1);
                    end else begin
                        q_d   = {q[N-2:0], q[N-1]};
                        idx_d = (idx == LAST) ? '0 : idx + CW'(1);
                    end

                    if (last_beat_c) begin
                        bcnt_d = '0;
                        loop_d = loop_cnt + 8'd1;
                        if (last_pass_c) begin
                            state_d = ST_DONE;
                            q_d     = Q_HOME;
                            idx_d   = '0;
                        end
                    end else begin
                        bcnt_d = bcnt + CW'(1);
                    end
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ring_seq_ctrl.sv
// Bench for ring_seq_ctrl: three instances (LOOPS = 0, 1, 2) share one stimulus stream.
// A position/beat/pass model per instance supplies expected outputs.
module tb_ring_seq_ctrl;

    localparam int NP = 17;
    localparam int CWP = 5;
`ifdef SEQ_REVERSE_EN
    localparam bit HAS_DIR = 1'b1;
`else
    localparam bit HAS_DIR = 1'b0;
`endif

    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic start = 1'b0;
    logic stop = 1'b0;
    logic out_ready = 1'b0;
    logic dir = 1'b0;

    logic [NP-1:0]  q_o      [3];
    logic [CWP-1:0] idx_o    [3];
    logic           vld_o    [3];
    logic           busy_o   [3];
    logic           done_o   [3];
    logic [7:0]     loop_o   [3];

    always #5 CLK = ~CLK;

    // Instance g runs with LOOPS = g.
    for (genvar g = 0; g < 3; g++) begin : g_dut
        ring_seq_ctrl #(
            .N     (NP),
            .LOOPS (g),
            .CW    (CWP)
        ) u_dut (
            .CLK       (CLK),
            .RST       (RST),
            .start     (start),
            .stop      (stop),
            .out_ready (out_ready),
`ifdef SEQ_REVERSE_EN
            .dir       (dir),
`endif
            .q         (q_o[g]),
            .idx       (idx_o[g]),
            .out_valid (vld_o[g]),
            .busy      (busy_o[g]),
            .done      (done_o[g]),
            .loop_cnt  (loop_o[g])
        );
    end

    int total = 0;
    int bad = 0;

    // Reference model: 0 = idle, 1 = running, 2 = finished
    int m_mode  [3];
    int m_pos   [3];
    int m_beats [3];
    int m_pass  [3];

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s inst%0d got=%0h exp=%0h at %0t", nm, k, act, exp, $time);
        end
    endtask

    // Apply one cycle of inputs and advance the model across the same edge.
    task automatic tick(input logic r, input logic s, input logic p, input logic rd, input logic d);
        RST = r; start = s; stop = p; out_ready = rd; dir = d;
        @(posedge CLK);
        for (int k = 0; k < 3; k++) begin
            if (r) begin
                m_mode[k] = 0; m_pos[k] = 0; m_beats[k] = 0; m_pass[k] = 0;
            end else begin
                case (m_mode[k])
                    0: if (s && !p) begin
                        m_mode[k] = 1; m_pos[k] = 0; m_beats[k] = 0; m_pass[k] = 0;
                    end
                    1: if (p) begin
                        m_mode[k] = 0; m_pos[k] = 0; m_beats[k] = 0;
                    end else if (rd) begin
                        m_pos[k] = (d && HAS_DIR) ? (m_pos[k] + NP - 1) % NP : (m_pos[k] + 1) % NP;
                        m_beats[k]++;
                        if (m_beats[k] == NP) begin
                            m_beats[k] = 0;
                            m_pass[k] = (m_pass[k] + 1) % 256;
                            if (k != 0 && m_pass[k] == k) begin
                                m_mode[k] = 2; m_pos[k] = 0;
                            end
                        end
                    end
                    default: m_mode[k] = 0;
                endcase
            end
        end
        #1;
    endtask

    task automatic check_model();
        for (int k = 0; k < 3; k++) begin
            chk("q",     k, 32'(q_o[k]),    32'(1) << m_pos[k]);
            chk("idx",   k, 32'(idx_o[k]),  32'(m_pos[k]));
            chk("valid", k, 32'(vld_o[k]),  32'(m_mode[k] == 1));
            chk("busy",  k, 32'(busy_o[k]), 32'(m_mode[k] == 1));
            chk("done",  k, 32'(done_o[k]), 32'(m_mode[k] == 2));
            chk("loops", k, 32'(loop_o[k]), 32'(m_pass[k]));
        end
    endtask

    typedef struct {
        logic rst, st, sp, rdy;
        int   e_idx;
        logic e_vld, e_done;
        int   e_loop;
    } vec_t;

    vec_t tbl [10];

    initial begin
        // Vectors for the LOOPS=1 instance: expected values after the edge.
        tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 0};
        tbl[1] = '{1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0, 0};
        tbl[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b1, 1'b0, 0};
        tbl[3] = '{1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b1, 1'b0, 0};
        tbl[4] = '{1'b0, 1'b0, 1'b0, 1'b1, 1, 1'b1, 1'b0, 0};
        tbl[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 2, 1'b1, 1'b0, 0};
        tbl[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 2, 1'b1, 1'b0, 0};
        tbl[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 3, 1'b1, 1'b0, 0};
        tbl[8] = '{1'b0, 1'b0, 1'b1, 1'b1, 0, 1'b0, 1'b0, 0};
        tbl[9] = '{1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0, 0};

        for (int i = 0; i < 10; i++) begin
            tick(tbl[i].rst, tbl[i].st, tbl[i].sp, tbl[i].rdy, 1'b0);
            chk("tbl_idx",   1, 32'(idx_o[1]),  32'(tbl[i].e_idx));
            chk("tbl_q",     1, 32'(q_o[1]),    32'(1) << tbl[i].e_idx);
            chk("tbl_valid", 1, 32'(vld_o[1]),  32'(tbl[i].e_vld));
            chk("tbl_done",  1, 32'(done_o[1]), 32'(tbl[i].e_done));
            chk("tbl_loops", 1, 32'(loop_o[1]), 32'(tbl[i].e_loop));
        end

        // Full forward pass at full rate; LOOPS=1 finishes, LOOPS=2 keeps going.
        tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        for (int b = 0; b < NP; b++) begin
            chk("pass_idx",   1, 32'(idx_o[1]), 32'(b));
            chk("pass_q",     1, 32'(q_o[1]),   32'(1) << b);
            chk("pass_valid", 1, 32'(vld_o[1]), 32'd1);
            tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        end
        chk("end_done",  1, 32'(done_o[1]), 32'd1);
        chk("end_valid", 1, 32'(vld_o[1]),  32'd0);
        chk("end_loops", 1, 32'(loop_o[1]), 32'd1);
        chk("l2_wrap",   2, 32'(idx_o[2]),  32'd0);
        chk("l2_q",      2, 32'(q_o[2]),    32'd1);
        chk("l2_loops",  2, 32'(loop_o[2]), 32'd1);
        // start while one instance is in DONE and another in RUN: both ignore it
        tick(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("after_done", 1, 32'(done_o[1]), 32'd0);
        chk("idle_busy",  1, 32'(busy_o[1]), 32'd0);
        chk("hold_loops", 1, 32'(loop_o[1]), 32'd1);
        chk("run_ign",    2, 32'(idx_o[2]),  32'd1);
        chk("run_loops",  2, 32'(loop_o[2]), 32'd1);
        for (int b = 0; b < NP - 1; b++) tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("l2_done",  2, 32'(done_o[2]), 32'd1);
        chk("l2_loops2",2, 32'(loop_o[2]), 32'd2);
        chk("l0_loops", 0, 32'(loop_o[0]), 32'd2);
        chk("l0_run",   0, 32'(vld_o[0]),  32'd1);

        // Continuous run stopped at idx 9 together with a handshake.
        tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int b = 0; b < 9; b++) tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("pre_stop", 0, 32'(idx_o[0]), 32'd9);
        tick(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("stop_idx",   0, 32'(idx_o[0]),  32'd0);
        chk("stop_q",     0, 32'(q_o[0]),    32'd1);
        chk("stop_valid", 0, 32'(vld_o[0]),  32'd0);
        chk("stop_done",  0, 32'(done_o[0]), 32'd0);
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("stop_nodone", 0, 32'(done_o[0]), 32'd0);

        // Reset mid-run at idx 5 after one completed pass.
        tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int b = 0; b < NP + 5; b++) tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("pre_rst_idx",   0, 32'(idx_o[0]),  32'd5);
        chk("pre_rst_loops", 0, 32'(loop_o[0]), 32'd1);
        tick(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("rst_idx",   0, 32'(idx_o[0]),  32'd0);
        chk("rst_q",     0, 32'(q_o[0]),    32'd1);
        chk("rst_valid", 0, 32'(vld_o[0]),  32'd0);
        chk("rst_loops", 0, 32'(loop_o[0]), 32'd0);

`ifdef SEQ_REVERSE_EN
        // Reverse pass: 0,16,15,...,1 then done.
        tick(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        for (int b = 0; b < NP; b++) begin
            chk("rev_idx", 1, 32'(idx_o[1]), 32'((NP - b) % NP));
            chk("rev_q",   1, 32'(q_o[1]),   32'(1) << ((NP - b) % NP));
            tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        end
        chk("rev_done",  1, 32'(done_o[1]), 32'd1);
        chk("rev_loops", 1, 32'(loop_o[1]), 32'd1);
`endif

        // Randomized traffic against the model.
        tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check_model();
        for (int c = 0; c < 3000; c++) begin
            tick(($urandom_range(0, 199) == 0),
                 ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 39) == 0),
                 ($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 1)));
            check_model();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
